// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bridge slave that buffers CPU-written bytes in a small FIFO and sends them 8N1 on txd.
// Define PARITY_EN to insert a parity bit (even, or odd when CTRL.odd_par=1) between data and stop.
module uart_tx_dev #(
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        txd
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divisor_q;
  logic [DIV_W-1:0] bit_div_q, bit_div_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             tx_en_q, irq_en_q, odd_par, ovf_q;
  logic             tick;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       head;
  logic             empty, full, busy, push_req, push, pop;
  logic             unused_wdata;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign busy         = (state_q != S_IDLE);
  assign push_req     = we && (addr == 2'd0);
  assign push         = push_req && !full;
  assign head         = mem[rd_ptr_q];
  assign irq          = irq_en_q && empty && !busy;
  assign txd          = txd_q;
  assign unused_wdata = ^wdata;

  // Register file and FIFO bookkeeping. A push against a full FIFO is lost even if a pop frees a slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      divisor_q <= DIV_RESET;
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (we && addr == 2'd2)
        divisor_q <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
      if (we && addr == 2'd3) begin
        tx_en_q  <= wdata[0];
        irq_en_q <= wdata[1];
      end
      if (we && addr == 2'd1 && wdata[3]) ovf_q <= 1'b0;
      if (push_req && full)               ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // NOTE: FIFO storage has no reset; cnt/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata[7:0];
  end

`ifdef PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      odd_par <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      if (we && addr == 2'd3) odd_par <= wdata[2];
      par_q <= par_d;
    end
  end
`else
  assign odd_par = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_div_q <= DIV_RESET;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_div_q <= bit_div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    bit_div_d = bit_div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tick      = (timer_q == '0);
    timer_d   = tick ? bit_div_q - DIV_W'(1) : timer_q - DIV_W'(1);
    pop       = 1'b0;
`ifdef PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q;
        pop     = tx_en_q && !empty;
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (tick) begin
          if (tx_en_q && !empty) pop = 1'b1;
          else                   state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d   = S_START;
      shift_d   = head;
      bit_div_d = divisor_q;
      timer_d   = divisor_q - DIV_W'(1);
`ifdef PARITY_EN
      par_d     = (^head) ^ odd_par;
`endif
    end

    // txd is registered from the next state, so the line changes on the same edge as the FSM.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd1:    rdata = {24'b0, 4'(cnt_q), ovf_q, empty, full, busy};
      2'd2:    rdata = 32'(divisor_q);
      2'd3:    rdata = {29'b0, odd_par, irq_en_q, tx_en_q};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: expected txd waveforms are expanded from byte lists
// into per-cycle bit streams (start, LSB-first data, optional parity, stop) and compared each cycle.
module tb_uart_tx_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        txd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  uart_tx_dev dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = rdata;
  endtask

  // Called right after the write that lets transmission start; the first start-bit
  // cycle is visible at the next negedge. exp_q holds the bytes expected on the line.
  task automatic check_stream(input int div, input logic odd, input logic irq_end, input string tag);
    logic       bits[$];
    logic [7:0] b;
    logic       par_bit;
    bits = {};
    foreach (exp_q[k]) begin
      b = exp_q[k];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      par_bit = (($countones(b) % 2) == 1) ^ odd;
`ifdef PARITY_EN
      bits.push_back(par_bit);
`endif
      bits.push_back(1'b1);
    end
    #1;
    check({tag, " pre-idle txd"}, 32'(txd), 32'd1);
    foreach (bits[j]) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        we   = 1'b0;
        addr = 2'd1;
        #1;
        check({tag, " txd"}, 32'(txd), 32'(bits[j]));
        check({tag, " busy"}, 32'(rdata[0]), 32'd1);
        check({tag, " irq busy"}, 32'(irq), 32'd0);
      end
    end
    @(negedge clk);
    addr = 2'd1;
    #1;
    check({tag, " end txd"}, 32'(txd), 32'd1);
    check({tag, " end busy"}, 32'(rdata[0]), 32'd0);
    check({tag, " end irq"}, 32'(irq), 32'(irq_end));
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b, b1, b2;
    int          div, n, bad;
    logic        odd;

    rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    read_reg(2'd1, d); check("reset status", d, 32'h4);
    read_reg(2'd2, d); check("reset divisor", d, 32'd434);
    read_reg(2'd3, d); check("reset ctrl", d, 32'h0);
    read_reg(2'd0, d); check("txdata reads zero", d, 32'h0);
    check("reset txd", 32'(txd), 32'd1);
    check("reset irq", 32'(irq), 32'd0);

    // Register field behaviour
    write_reg(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd3, d);
`ifdef PARITY_EN
    check("ctrl mask", d, 32'h7);
`else
    check("ctrl mask", d, 32'h3);
`endif
    check("irq idle empty", 32'(irq), 32'd1);
    write_reg(2'd3, 32'h0);
    check("irq disabled", 32'(irq), 32'd0);
    write_reg(2'd2, 32'h0);
    read_reg(2'd2, d); check("divisor zero->1", d, 32'd1);
    write_reg(2'd2, 32'hABCD_0007);
    read_reg(2'd2, d); check("divisor width", d, 32'd7);

    // Single 0xA5 frame at divisor 4: 40 busy cycles
    write_reg(2'd2, 32'd4);
    write_reg(2'd3, 32'd1);
    write_reg(2'd0, 32'hA5);
    exp_q = {8'hA5};
    check_stream(4, 1'b0, 1'b0, "a5");

    // Overflow, ovf clear, back-to-back drain
    write_reg(2'd2, 32'd2);
    write_reg(2'd3, 32'd0);
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      write_reg(2'd0, 32'(b));
      if (k < 4) exp_q.push_back(b);
    end
    read_reg(2'd1, d); check("full status", d, 32'h4A);
    write_reg(2'd1, 32'h8);
    read_reg(2'd1, d); check("ovf cleared", d, 32'h42);
    write_reg(2'd3, 32'd1);
    check_stream(2, 1'b0, 1'b0, "burst");

    // Clearing tx_en on the pop edge: frame finishes, second byte stays queued
    write_reg(2'd2, 32'd1);
    write_reg(2'd3, 32'd0);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    write_reg(2'd0, 32'(b1));
    write_reg(2'd0, 32'(b2));
    write_reg(2'd3, 32'd1);
    addr = 2'd3; wdata = 32'd0; we = 1'b1;
    exp_q = {b1};
    check_stream(1, 1'b0, 1'b0, "txen off");
    read_reg(2'd1, d); check("retained status", d, 32'h10);
    repeat (5) @(negedge clk);
    #1;
    check("retained txd", 32'(txd), 32'd1);
    check("retained status later", rdata, 32'h10);
    write_reg(2'd3, 32'd1);
    exp_q = {b2};
    check_stream(1, 1'b0, 1'b0, "resume");

    // Interrupt timing
    write_reg(2'd3, 32'd3);
    check("irq on idle", 32'(irq), 32'd1);
    write_reg(2'd2, 32'd1);
    write_reg(2'd0, 32'h00);
    check("irq after push", 32'(irq), 32'd0);
    exp_q = {8'h00};
    check_stream(1, 1'b0, 1'b1, "irq frame");
    write_reg(2'd3, 32'd1);
    check("irq off on ctrl write", 32'(irq), 32'd0);

    // Randomised bursts, divisors and parity sense
    for (int r = 0; r < 8; r++) begin
      div = int'($urandom_range(1, 5));
      odd = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 4));
      write_reg(2'd3, {29'b0, odd, 2'b00});
      write_reg(2'd2, 32'(div));
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        write_reg(2'd0, 32'(b));
        exp_q.push_back(b);
      end
      write_reg(2'd3, {29'b0, odd, 2'b01});
      check_stream(div, odd, 1'b0, "random");
    end

`ifdef PARITY_EN
    // Parity sense for 0x03: odd -> 1, even -> 0
    write_reg(2'd2, 32'd1);
    write_reg(2'd3, 32'd5);
    write_reg(2'd0, 32'h03);
    exp_q = {8'h03};
    check_stream(1, 1'b1, 1'b0, "parity odd");
    write_reg(2'd3, 32'd1);
    write_reg(2'd0, 32'h03);
    exp_q = {8'h03};
    check_stream(1, 1'b0, 1'b0, "parity even");
`endif

    // Reset in the middle of a frame
    write_reg(2'd2, 32'd4);
    write_reg(2'd3, 32'd1);
    write_reg(2'd0, 32'($urandom));
    write_reg(2'd0, 32'($urandom));
    repeat (14) @(negedge clk);
    addr = 2'd1;
    #1;
    check("busy before reset", 32'(rdata[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset txd", 32'(txd), 32'd1);
    check("post-reset status", rdata, 32'h4);
    check("post-reset irq", 32'(irq), 32'd0);
    addr = 2'd2; #1;
    check("post-reset divisor", rdata, 32'd434);
    addr = 2'd3; #1;
    check("post-reset ctrl", rdata, 32'h0);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("quiet after reset", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
